// File: rtl/la_uart_pkg.sv
// la_uart_pkg: shared types and constants for the uart_tx6 arbiter slice
// Contents: arbiter state encoding, requester ceiling, default stall timeout,
// and small index helpers used by the picker and the top level.
package la_uart_pkg;
   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;
   localparam int LA_MAX_REQ     = 4;
   localparam int LA_DEF_TIMEOUT = 1024;
   function automatic int la_idx_w(input int n);
      return (n < 3) ? 1 : $clog2(n);
   endfunction
   // Distance of a lane from the slot just after the previous owner, so the
   // smallest distance among requesters is the round-robin winner.
   function automatic int la_dist(input int lane, input int last, input int n);
      return (lane - last - 1 + 2 * n) % n;
   endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester lanes plus uart_tx6 FIFO write port
// master: requesters and FIFO (drive req/din/din_valid/din_last/utx_buffer_full)
// slave : arbiter (drives din_ready/grant/data_tx/utx_buffer_write/busy/timeout_err)
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] din;
   logic [NUM_REQ-1:0]   din_valid;
   logic [NUM_REQ-1:0]   din_last;
   logic [NUM_REQ-1:0]   din_ready;
   logic [NUM_REQ-1:0]   grant;
   logic [7:0]           data_tx;
   logic                 utx_buffer_write;
   logic                 utx_buffer_full;
   logic                 busy;
   logic                 timeout_err;
   modport master (
      output req, din, din_valid, din_last, utx_buffer_full,
      input  din_ready, grant, data_tx, utx_buffer_write, busy, timeout_err
   );
   modport slave (
      input  req, din, din_valid, din_last, utx_buffer_full,
      output din_ready, grant, data_tx, utx_buffer_write, busy, timeout_err
   );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker
// req        : per-lane request vector
// last_grant : index of the previous owner; search starts just above it
// win_oh     : one-hot winner (zero when nothing requests)
// win_idx    : winner index (zero when nothing requests)
module rr_pick
   import la_uart_pkg::*;
#(
   parameter int NUM_REQ = 2,
   localparam int IW     = la_idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last_grant,
   output logic [NUM_REQ-1:0] win_oh,
   output logic [IW-1:0]      win_idx
);
   logic [IW:0] w_best;
   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      w_best  = '1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req[i] && (IW+1)'(la_dist(i, int'(last_grant), NUM_REQ)) < w_best) begin
            w_best     = (IW+1)'(la_dist(i, int'(last_grant), NUM_REQ));
            win_oh     = '0;
            win_oh[i]  = 1'b1;
            win_idx    = IW'(i);
         end
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin sharing of the uart_tx6 FIFO
// clk         : system clock
// btnCpuReset : asynchronous active-low reset
// bus         : requester lanes (req/din/din_valid/din_last/din_ready/grant)
//               and FIFO port (data_tx/utx_buffer_write/utx_buffer_full),
//               plus busy and the one-cycle timeout_err pulse
module uart_tx_arbiter
   import la_uart_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = LA_DEF_TIMEOUT
) (
   input logic              clk,
   input logic              btnCpuReset,
   uart_tx_arbiter_if.slave bus
);
   localparam int IW = la_idx_w(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT);

   state_t             r_state, w_state_nx;
   logic [NUM_REQ-1:0] r_grant, w_grant_nx;
   logic [IW-1:0]      r_gidx, w_gidx_nx;
   logic [IW-1:0]      r_last, w_last_nx;
   logic [CW-1:0]      r_cnt, w_cnt_nx;
   logic               r_terr, w_terr_nx;
   logic [7:0]         r_data;
   logic               r_wr;

   logic [NUM_REQ-1:0] w_pick_oh;
   logic [IW-1:0]      w_pick_idx;
   logic [NUM_REQ-1:0] w_ready;
   logic [7:0]         w_byte;
   logic               w_hs, w_last_hs, w_abort, w_tick, w_to;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req        (bus.req),
      .last_grant (r_last),
      .win_oh     (w_pick_oh),
      .win_idx    (w_pick_idx)
   );

   // Ready is withheld the cycle after a write so buffer_full can catch up.
   assign w_ready   = (r_state == XFER && !bus.utx_buffer_full && !r_wr) ? r_grant : '0;
   assign w_hs      = |(w_ready & bus.din_valid);
   assign w_last_hs = w_hs && |(r_grant & bus.din_last);
   assign w_abort   = r_state == XFER && !(|(r_grant & bus.req));
   // Only cycles where the owner could have sent but did not count as stall.
   assign w_tick    = |(w_ready & ~bus.din_valid);
   assign w_to      = w_tick && r_cnt == CW'(TIMEOUT - 1);

   always_comb begin
      w_byte = '0;
      for (int i = 0; i < NUM_REQ; i++)
         w_byte = w_byte | (bus.din[8*i +: 8] & {8{r_grant[i]}});
   end

   always_comb begin
      w_state_nx = r_state;
      w_grant_nx = r_grant;
      w_gidx_nx  = r_gidx;
      w_last_nx  = r_last;
      w_cnt_nx   = r_cnt;
      w_terr_nx  = 1'b0;
      if (r_state == IDLE) begin
         if (|bus.req) begin
            w_state_nx = XFER;
            w_grant_nx = w_pick_oh;
            w_gidx_nx  = w_pick_idx;
            w_cnt_nx   = '0;
         end
      end else if (w_last_hs || w_abort || w_to) begin
         w_state_nx = IDLE;
         w_grant_nx = '0;
         w_last_nx  = r_gidx;
         w_cnt_nx   = '0;
         // A last-byte handshake never coincides with a stall tick, so only
         // the abort has to mask the error pulse.
         w_terr_nx  = w_to && !w_abort;
      end else if (w_hs) begin
         w_cnt_nx   = '0;
      end else if (w_tick) begin
         w_cnt_nx   = r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge btnCpuReset) begin
      if (!btnCpuReset) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_gidx  <= '0;
         r_last  <= IW'(NUM_REQ - 1);
         r_cnt   <= '0;
         r_terr  <= 1'b0;
         r_data  <= 8'h00;
         r_wr    <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_grant <= w_grant_nx;
         r_gidx  <= w_gidx_nx;
         r_last  <= w_last_nx;
         r_cnt   <= w_cnt_nx;
         r_terr  <= w_terr_nx;
         r_wr    <= w_hs;
         if (w_hs) r_data <= w_byte;
      end
   end

   assign bus.din_ready        = w_ready;
   assign bus.grant            = r_grant;
   assign bus.data_tx          = r_data;
   assign bus.utx_buffer_write = r_wr;
   assign bus.busy             = |r_grant;
   assign bus.timeout_err      = r_terr;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
   localparam int NR = 2;
   localparam int TO = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   terr_cnt = 0;
   logic [8:0] lq [NR][$];
   logic [7:0] exp_q [$];
   logic [7:0] wq [$];

   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

   uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .btnCpuReset (rst_n),
      .bus         (bus)
   );

   always @(negedge clk) begin
      if (bus.utx_buffer_write) wq.push_back(bus.data_tx);
      if (bus.timeout_err) terr_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   task automatic do_reset();
      bus.req = '0;
      bus.din = '0;
      bus.din_valid = '0;
      bus.din_last = '0;
      bus.utx_buffer_full = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wq.delete();
      terr_cnt = 0;
   endtask

   task automatic build_exp();
      logic [8:0] q [NR][$];
      logic [8:0] e;
      int last, cur;
      logic done;
      for (int i = 0; i < NR; i++) q[i] = lq[i];
      exp_q.delete();
      last = NR - 1;
      while (q[0].size() != 0 || q[1].size() != 0) begin
         cur = 0;
         for (int k = NR; k >= 1; k--)
            if (q[(last + k) % NR].size() != 0) cur = (last + k) % NR;
         done = 1'b0;
         while (!done && q[cur].size() != 0) begin
            e = q[cur].pop_front();
            exp_q.push_back(e[7:0]);
            done = e[8];
         end
         last = cur;
      end
   endtask

   task automatic drive(input int gmax, input int fpct, input int fs, input int fl, input int budget);
      int   gap [NR];
      logic hs [NR];
      int   cyc;
      logic win;
      cyc = 0;
      for (int i = 0; i < NR; i++) begin gap[i] = 0; hs[i] = 1'b0; end
      while (lq[0].size() != 0 || lq[1].size() != 0) begin
         if (cyc == budget) begin
            checks++; errors++;
            $display("FAIL drive_budget got %0d cycles exp completion", cyc);
            break;
         end
         @(negedge clk);
         for (int i = 0; i < NR; i++)
            if (hs[i]) begin
               void'(lq[i].pop_front());
               gap[i] = $urandom_range(gmax, 0);
            end
         for (int i = 0; i < NR; i++) begin
            bus.req[i] = lq[i].size() != 0;
            if (lq[i].size() != 0 && gap[i] == 0) begin
               bus.din_valid[i] = 1'b1;
               bus.din[8*i +: 8] = lq[i][0][7:0];
               bus.din_last[i] = lq[i][0][8];
            end else begin
               bus.din_valid[i] = 1'b0;
               bus.din_last[i] = 1'b0;
               if (gap[i] > 0) gap[i]--;
            end
         end
         win = cyc >= fs && cyc < fs + fl;
         bus.utx_buffer_full = win || ($urandom_range(99, 0) < fpct);
         #1;
         for (int i = 0; i < NR; i++) hs[i] = bus.din_valid[i] & bus.din_ready[i];
         if (win) begin
            checks++;
            if (bus.din_ready !== 2'b00) begin errors++; $display("FAIL full_ready got %b exp 00 cyc %0d", bus.din_ready, cyc); end
            if (cyc > fs) begin
               checks++;
               if (bus.utx_buffer_write !== 1'b0) begin errors++; $display("FAIL full_write got %b exp 0 cyc %0d", bus.utx_buffer_write, cyc); end
            end
         end
         cyc++;
      end
      bus.req = '0;
      bus.din_valid = '0;
      bus.din_last = '0;
      bus.utx_buffer_full = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", bus.grant); end
      checks++; if (bus.din_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", bus.din_ready); end
      checks++; if (bus.data_tx !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", bus.data_tx); end
      checks++; if (bus.utx_buffer_write !== 1'b0) begin errors++; $display("FAIL reset_write got %b exp 0", bus.utx_buffer_write); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr got %b exp 0", bus.timeout_err); end
   endtask

   task automatic test_single();
      do_reset();
      bus.req = 2'b01;
      bus.din[7:0] = 8'h48;
      bus.din_valid = 2'b01;
      bus.din_last = 2'b00;
      @(negedge clk);
      checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", bus.grant); end
      checks++; if (bus.din_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", bus.din_ready); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", bus.busy); end
      @(negedge clk);
      checks++; if (bus.utx_buffer_write !== 1'b1 || bus.data_tx !== 8'h48) begin errors++; $display("FAIL single_wr0 got %b/%h exp 1/48", bus.utx_buffer_write, bus.data_tx); end
      checks++; if (bus.din_ready !== 2'b00) begin errors++; $display("FAIL single_gap_ready got %b exp 00", bus.din_ready); end
      bus.din[7:0] = 8'h49;
      bus.din_last = 2'b01;
      @(negedge clk);
      checks++; if (bus.utx_buffer_write !== 1'b0 || bus.din_ready !== 2'b01) begin errors++; $display("FAIL single_mid got %b/%b exp 0/01", bus.utx_buffer_write, bus.din_ready); end
      @(negedge clk);
      checks++; if (bus.utx_buffer_write !== 1'b1 || bus.data_tx !== 8'h49) begin errors++; $display("FAIL single_wr1 got %b/%h exp 1/49", bus.utx_buffer_write, bus.data_tx); end
      checks++; if (bus.grant !== 2'b00 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_release got %b/%b exp 00/0", bus.grant, bus.busy); end
      bus.req = '0;
      bus.din_valid = '0;
      bus.din_last = '0;
      repeat (3) @(negedge clk);
      checks++; if (wq.size() != 2) begin errors++; $display("FAIL single_count got %0d exp 2", wq.size()); end
      checks++; if (terr_cnt != 0) begin errors++; $display("FAIL single_terr got %0d exp 0", terr_cnt); end
   endtask

   task automatic test_contention();
      do_reset();
      lq[0].push_back(9'h001); lq[0].push_back(9'h102); lq[0].push_back(9'h103);
      lq[1].push_back(9'h1A0);
      build_exp();
      drive(0, 0, 0, 0, 200);
      checks++; if (wq.size() != exp_q.size()) begin errors++; $display("FAIL cont_count got %0d exp %0d", wq.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++; if (wq[i] !== exp_q[i]) begin errors++; $display("FAIL cont_byte%0d got %h exp %h", i, wq[i], exp_q[i]); end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int b = 0; b < 6; b++) lq[0].push_back({b == 5, 8'(8'h30 + b)});
      build_exp();
      drive(0, 0, 5, 20, 300);
      checks++; if (wq.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d exp %0d", wq.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++; if (wq[i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte%0d got %h exp %h", i, wq[i], exp_q[i]); end
      end
      checks++; if (terr_cnt != 0) begin errors++; $display("FAIL bp_terr got %0d exp 0", terr_cnt); end
   endtask

   task automatic test_timeout();
      int err_at, g1_at;
      do_reset();
      err_at = -1;
      g1_at = -1;
      bus.req = 2'b11;
      bus.din_valid = 2'b10;
      bus.din[15:8] = 8'hB1;
      bus.din_last = 2'b10;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (c == 1) begin
            checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL to_grant0 got %b exp 01", bus.grant); end
         end
         if (bus.timeout_err && err_at < 0) begin err_at = c; bus.req[0] = 1'b0; end
         if (bus.grant == 2'b10 && g1_at < 0) g1_at = c;
         if (g1_at > 0 && bus.utx_buffer_write) begin bus.req = '0; bus.din_valid = '0; bus.din_last = '0; end
      end
      checks++; if (err_at != TO + 1) begin errors++; $display("FAIL to_err_cycle got %0d exp %0d", err_at, TO + 1); end
      checks++; if (terr_cnt != 1) begin errors++; $display("FAIL to_err_count got %0d exp 1", terr_cnt); end
      checks++; if (g1_at != TO + 2) begin errors++; $display("FAIL to_grant1_cycle got %0d exp %0d", g1_at, TO + 2); end
      checks++; if (wq.size() != 1 || wq[0] !== 8'hB1) begin errors++; $display("FAIL to_data got %0d/%h exp 1/b1", wq.size(), wq[0]); end
   endtask

   task automatic test_abort();
      do_reset();
      bus.req = 2'b10;
      bus.din_valid = 2'b10;
      bus.din[15:8] = 8'hC1;
      bus.din_last = 2'b00;
      @(negedge clk);
      checks++; if (bus.grant !== 2'b10) begin errors++; $display("FAIL abort_grant got %b exp 10", bus.grant); end
      @(negedge clk);
      checks++; if (bus.utx_buffer_write !== 1'b1 || bus.data_tx !== 8'hC1) begin errors++; $display("FAIL abort_wr got %b/%h exp 1/c1", bus.utx_buffer_write, bus.data_tx); end
      bus.req = 2'b00;
      bus.din[15:8] = 8'hC2;
      @(negedge clk);
      checks++; if (bus.grant !== 2'b00 || bus.din_ready !== 2'b00) begin errors++; $display("FAIL abort_release got %b/%b exp 00/00", bus.grant, bus.din_ready); end
      bus.din_valid = '0;
      repeat (4) @(negedge clk);
      checks++; if (wq.size() != 1) begin errors++; $display("FAIL abort_count got %0d exp 1", wq.size()); end
      checks++; if (terr_cnt != 0) begin errors++; $display("FAIL abort_terr got %0d exp 0", terr_cnt); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.req = 2'b11;
      bus.din_valid = 2'b11;
      bus.din = 16'h6B5A;
      bus.din_last = 2'b10;
      @(negedge clk);
      @(negedge clk);
      checks++; if (bus.utx_buffer_write !== 1'b1) begin errors++; $display("FAIL rmid_pre_wr got %b exp 1", bus.utx_buffer_write); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.grant !== 2'b00 || bus.din_ready !== 2'b00) begin errors++; $display("FAIL rmid_grant got %b/%b exp 00/00", bus.grant, bus.din_ready); end
      checks++; if (bus.data_tx !== 8'h00 || bus.utx_buffer_write !== 1'b0) begin errors++; $display("FAIL rmid_data got %h/%b exp 00/0", bus.data_tx, bus.utx_buffer_write); end
      checks++; if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rmid_flags got %b/%b exp 0/0", bus.busy, bus.timeout_err); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL rmid_regrant got %b exp 01", bus.grant); end
      bus.req = '0;
      bus.din_valid = '0;
      bus.din_last = '0;
   endtask

   task automatic test_random();
      int np, len;
      for (int it = 0; it < 6; it++) begin
         do_reset();
         for (int l = 0; l < NR; l++) begin
            np = $urandom_range(3, 1);
            for (int p = 0; p < np; p++) begin
               len = $urandom_range(4, 1);
               for (int b = 0; b < len; b++) lq[l].push_back({b == len - 1, 8'($urandom)});
            end
         end
         build_exp();
         drive(3, 30, 0, 0, 2000);
         checks++; if (wq.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count got %0d exp %0d", it, wq.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (wq[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_byte%0d got %h exp %h", it, i, wq[i], exp_q[i]); end
         end
         checks++; if (terr_cnt != 0) begin errors++; $display("FAIL rnd%0d_terr got %0d exp 0", it, terr_cnt); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_timeout();
      test_abort();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
